// File: rtl/present_encryptor_hs.sv
// present_encryptor_hs: iterative PRESENT-80/128 block encryptor, one round
// per clock, with valid/ready handshakes on key, plaintext and ciphertext.
// The master key is retained across blocks until reset, a new key handshake
// or (optionally) zeroization.
// Optional feature macro: PRESENT_KEY_ZEROIZE_EN adds key_clear_i, which wipes
// all key-dependent state and returns the core to IDLE.
module present_encryptor_hs #(
    parameter int KEY_WIDTH = 80,
    parameter int ROUNDS    = 31
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
`ifdef PRESENT_KEY_ZEROIZE_EN
    input  logic                 key_clear_i,
`endif
    input  logic [KEY_WIDTH-1:0] key_i,
    input  logic                 key_valid_i,
    output logic                 key_ready_o,
    input  logic [63:0]          pt_i,
    input  logic                 pt_valid_i,
    output logic                 pt_ready_o,
    output logic [63:0]          ct_o,
    output logic                 ct_valid_o,
    input  logic                 ct_ready_i,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    fsm_t                 fsm_state;
    logic                 key_loaded;
    logic [KEY_WIDTH-1:0] master_key;
    logic [KEY_WIDTH-1:0] work_key;
    logic [KEY_WIDTH-1:0] key_next;
    logic [63:0]          cipher_state;
    logic [63:0]          round_key;
    logic [63:0]          round_out;
    logic [4:0]           cnt;
    logic                 zeroize;

    // Elaboration-time guards on the parameter ranges.
    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
        $error("present_encryptor_hs: KEY_WIDTH must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_encryptor_hs: ROUNDS must be in 1..31");
    end

`ifdef PRESENT_KEY_ZEROIZE_EN
    assign zeroize = key_clear_i;
`else
    assign zeroize = 1'b0;
`endif

    // PRESENT 4-bit S-box: C56B90AD3EF84712.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit j moves to position 16*j mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) begin
            y[(16 * j) % 63] = x[j];
        end
        y[63] = x[63];
        return y;
    endfunction

    assign round_key = work_key[KEY_WIDTH-1 -: 64];
    assign round_out = p_layer(sbox_layer(cipher_state ^ round_key));

    // Key schedule step for the round currently held in cnt.
    if (KEY_WIDTH == 128) begin : g_key128
        logic [127:0] rot;
        assign rot = {work_key[66:0], work_key[127:67]};
        always_comb begin
            // NOTE: start every always_comb output from a full default so no path leaves it unassigned (which would infer a latch).
            key_next           = rot;
            key_next[127:124]  = sbox(rot[127:124]);
            key_next[123:120]  = sbox(rot[123:120]);
            key_next[66:62]    = rot[66:62] ^ cnt;
        end
    end else if (KEY_WIDTH == 80) begin : g_key80
        logic [79:0] rot;
        assign rot = {work_key[18:0], work_key[79:19]};
        always_comb begin
            key_next         = rot;
            key_next[79:76]  = sbox(rot[79:76]);
            key_next[19:15]  = rot[19:15] ^ cnt;
        end
    end else begin : g_key_none
        assign key_next = '0;
    end

    // Ready/busy depend only on registered state, never on a valid input.
    assign key_ready_o = (fsm_state == IDLE);
    assign pt_ready_o  = (fsm_state == IDLE) && key_loaded;
    assign busy_o      = (fsm_state != IDLE);

    // Control FSM plus datapath registers: accept, iterate rounds, hold result.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_ni) begin
            fsm_state    <= IDLE;
            key_loaded   <= 1'b0;
            master_key   <= '0;
            work_key     <= '0;
            cipher_state <= '0;
            ct_o         <= '0;
            ct_valid_o   <= 1'b0;
            cnt          <= '0;
        end else if (zeroize) begin
            fsm_state    <= IDLE;
            key_loaded   <= 1'b0;
            master_key   <= '0;
            work_key     <= '0;
            cipher_state <= '0;
            ct_o         <= '0;
            ct_valid_o   <= 1'b0;
        end else begin
            case (fsm_state)
                IDLE: begin
                    if (key_valid_i) begin
                        master_key <= key_i;
                        key_loaded <= 1'b1;
                    end
                    if (pt_valid_i && key_loaded) begin
                        cipher_state <= pt_i;
                        // A key offered in the same cycle takes effect at once.
                        work_key     <= key_valid_i ? key_i : master_key;
                        cnt          <= 5'd1;
                        fsm_state    <= RUN;
                    end
                end
                RUN: begin
                    cipher_state <= round_out;
                    work_key     <= key_next;
                    // Counter holds at the last round so it never wraps.
                    if (cnt == LAST_ROUND) begin
                        fsm_state <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    // First DONE edge applies final whitening; later edges wait for the drain.
                    if (!ct_valid_o) begin
                        ct_o       <= cipher_state ^ round_key;
                        ct_valid_o <= 1'b1;
                    end else if (ct_ready_i) begin
                        ct_valid_o <= 1'b0;
                        fsm_state  <= IDLE;
                    end
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/present_encryptor_hs.md
Name: present_encryptor_hs

Overview:
Parametrised, handshake-driven successor to the existing PRESENT encryptor core.
- Supports 80- or 128-bit keys via parameter.
- Retains the loaded master key across any number of plaintext blocks.
- Uses valid/ready handshakes on key, plaintext and ciphertext, replacing blind load strobes and fixed-time sampling.
- Iterative, one round per cycle; sits between the host interface and the output buffer.

Parameters:
KEY_WIDTH, 80, master key width; legal values 80 or 128 (any other value is a compile-time error)
ROUNDS, 31, number of full rounds before final whitening; range 1..31

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
key_i  in  KEY_WIDTH  master key
key_valid_i  in  1  key offer
key_ready_o  out  1  key accepted when key_valid_i & key_ready_o
pt_i  in  64  plaintext
pt_valid_i  in  1  plaintext offer
pt_ready_o  out  1  plaintext accepted when pt_valid_i & pt_ready_o
ct_o  out  64  ciphertext
ct_valid_o  out  1  ciphertext valid
ct_ready_i  in  1  downstream accepts ciphertext
busy_o  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_ni low at a rising edge), applicable in any state including mid-encryption:
  - FSM goes to IDLE; key_loaded=0; master key, state, working key, ct_o and round counter all cleared to 0; ct_valid_o=0.
  - No partial result is ever emitted after reset.
- FSM states: IDLE, RUN, DONE.
- Ready signals are registered-state functions only; there is no combinational path from any valid input to any ready output.
  - key_ready_o = (FSM==IDLE).
  - pt_ready_o = (FSM==IDLE) & key_loaded.
- Key handshake in IDLE: master key <= key_i; key_loaded <= 1.
- Simultaneous key and plaintext handshake in the same IDLE cycle: both are accepted, and encryption uses the new key_i directly.
- Plaintext handshake at edge e0:
  - state <= pt_i; working key <= master key (or key_i if simultaneous); cnt <= 1; FSM -> RUN.
- RUN, each edge with cnt = i (1..ROUNDS):
  - state <= pLayer(sBoxLayer(state ^ K[top 64]))
  - K <= update(K, i); cnt <= i+1.
  - After the edge with cnt==ROUNDS, FSM -> DONE.
- Round operations:
  - sBoxLayer uses the standard PRESENT 4-bit S-box C56B90AD3EF84712 on all 16 nibbles.
  - pLayer maps bit j to bit 16*j mod 63; bit 63 is fixed.
- Key update, 80-bit:
  - rotate left 61;
  - S-box on bits [79:76];
  - bits [19:15] ^= i (5-bit).
- Key update, 128-bit:
  - rotate left 61;
  - S-box on [127:124] and [123:120];
  - bits [66:62] ^= i.
- DONE entry edge: ct_o <= state ^ K[top 64]; ct_valid_o <= 1.
- Latency: ct_valid_o rises exactly ROUNDS+1 edges after the plaintext-accept edge (32 for the default).
- DONE with ct_ready_i=0: ct_o and ct_valid_o held stable indefinitely.
- DONE with ct_ready_i=1: at the next edge ct_valid_o <= 0 and FSM -> IDLE. ct_o keeps its last value.
- Throughput: one block per ROUNDS+3 cycles at most (IDLE accept, rounds, DONE, drain).
- key_valid_i or pt_valid_i asserted outside IDLE is ignored and not acknowledged.
- Round counter is 5 bits wide. It never wraps within one operation and is reset to 1 on each plaintext accept.

Optional Feature:
Macro: PRESENT_KEY_ZEROIZE_EN
- Defined:
  - Adds input port key_clear_i (1 bit).
  - key_clear_i high at an edge, in any state, clears master key, working key, state and ct_o to 0, clears key_loaded, drops ct_valid_o, and forces FSM -> IDLE.
  - key_clear_i has priority over all handshakes in that cycle, but not over rst_ni.
- Undefined: the port is absent, and the key persists until reset or a new key handshake.

Test Plan:
1. KEY_WIDTH=80: key 0, pt 0000000000000000 -> ct_o 5579C1387B228445, ct_valid_o rising exactly 32 edges after the pt accept edge.
2. KEY_WIDTH=80: key FFFFFFFFFFFFFFFFFFFF loaded once, then pt 0 -> E72C46C0F5945049; then pt FFFFFFFFFFFFFFFF with no key reload -> 3333DCD3213210D2 (checks key retention).
3. KEY_WIDTH=128: key 0, pt 0 -> 96DB702A2E6900AF; key all-F, pt all-F -> 628D9FBD4218E5B4.
4. Backpressure: hold ct_ready_i=0 for 10 cycles in DONE -> ct_o and ct_valid_o stable, pt_ready_o=0; then assert ct_ready_i -> IDLE on the next edge, and pt_ready_o=1 the cycle after.
5. Protocol edge cases:
   - pt_valid_i before any key -> never accepted, with pt_ready_o=0.
   - Simultaneous key 0 / pt FFFFFFFFFFFFFFFF in IDLE -> A112FFC72F68417B.
   - rst_ni low at round 15 -> ct_valid_o stays 0, and key_loaded is cleared.
6. With PRESENT_KEY_ZEROIZE_EN: key_clear_i pulsed at round 10 -> FSM IDLE, ct_valid_o never asserts, pt_ready_o=0 until a new key handshake.
